dijkstra_mem_responder: RTL and testbench

- Memory-side responder that services the 16-bit word read/write requests issued by the Dijkstra algorithm's memory initiator.
- Holds graph/distance words in an internal array and drives wait_request, read/write-ready pulses and the write response.
- Used as the memory model for the pathfinder bench and as a small on-chip store for reduced graphs.

---
 rtl/dijkstra_mem_pkg.sv | 19 +
 rtl/dijkstra_mem_array.sv | 32 +++
 rtl/dijkstra_mem_responder.sv | 149 ++++++++++++++
 tb/tb_dijkstra_mem_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dijkstra_mem_pkg.sv
// Shared types and widths for the Dijkstra memory responder.
package dijkstra_mem_pkg;

  localparam int MEM_WORD_W = 16;
  localparam int MEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    READ_RESP  = 2'd2,
    WRITE_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/dijkstra_mem_array.sv
// DEPTH x 16 single-port store: synchronous write, registered read.
// Contents are deliberately not reset.
module dijkstra_mem_array
  import dijkstra_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [MEM_WORD_W-1:0] wdata_i,
  output logic [MEM_WORD_W-1:0] rdata_o
);

  logic [MEM_WORD_W-1:0] mem_q [DEPTH];
  logic [MEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read data is only refreshed on a read accept, so it stays stable
  // through the whole read latency window.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dijkstra_mem_responder.sv
// Word-addressed memory responder for the Dijkstra initiator.
// Optional DIJKSTRA_MEM_RESPONDER_STALL_EN adds LFSR-driven random stalls in IDLE.
module dijkstra_mem_responder
  import dijkstra_mem_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int                    DEPTH          = 1024,
  parameter int                    READ_LATENCY   = 2,
  parameter logic [MEM_WORD_W-1:0] OOR_READ_VALUE = 16'hFFFF
) (
  input  logic                  mem_clock,
  input  logic                  mem_reset,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [MEM_WORD_W-1:0] mem_write_data,
  output logic [MEM_WORD_W-1:0] mem_read_data,
  output logic                  mem_read_ready,
  output logic                  mem_write_ready,
  output logic [1:0]            mem_write_response,
  output logic                  wait_request,
  output logic [15:0]           error_count
);

  localparam int         IW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  wait_q;
  logic                  rd_ready_q;
  logic                  wr_ready_q;
  resp_t                 resp_q;
  logic                  rd_ok_q;
  logic [MEM_WORD_W-1:0] hold_q;
  logic [15:0]           err_q;
  logic [15:0]           err_d;

  logic [MEM_ADDR_W-1:0] offset;
  logic                  addr_ok;
  logic [IW-1:0]         idx;
  logic                  stall;
  logic                  accept;
  logic                  arr_we;
  logic                  arr_re;
  logic [MEM_WORD_W-1:0] arr_rdata;
  logic [1:0]            err_inc;
  logic [16:0]           err_sum;

  // Decode: offset wraps mod 2^32, so addresses below BASE_ADDR land far out of range.
  assign offset  = mem_addr - BASE_ADDR;
  assign addr_ok = ~offset[0] && (offset[MEM_ADDR_W-1:IW+1] == '0);
  assign idx     = offset[IW:1];

`ifdef DIJKSTRA_MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge mem_clock or negedge mem_reset) begin
    if (!mem_reset) lfsr_q <= 16'hACE1;
    else            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (state_q == IDLE) && (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign accept = (state_q == IDLE) && !stall && (mem_read_enable || mem_write_enable);
  assign arr_we = accept && mem_write_enable && addr_ok;
  assign arr_re = accept && !mem_write_enable;

  // Errors are charged at accept: a dropped read plus a bad address can add two.
  assign err_inc = accept ? ({1'b0, mem_read_enable && mem_write_enable} + {1'b0, !addr_ok})
                          : 2'd0;
  assign err_sum = {1'b0, err_q} + {15'd0, err_inc};
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  dijkstra_mem_array #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_array (
    .clk_i   (mem_clock),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (idx),
    .wdata_i (mem_write_data),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge mem_clock or negedge mem_reset) begin
    if (!mem_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wait_q     <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      resp_q     <= RESP_OKAY;
      rd_ok_q    <= 1'b0;
      hold_q     <= '0;
      err_q      <= 16'd0;
    end else begin
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      err_q      <= err_d;
      if (rd_ready_q) hold_q <= mem_read_data;
      case (state_q)
        IDLE: begin
          if (accept) begin
            wait_q <= 1'b1;
            if (mem_write_enable) begin
              state_q    <= WRITE_RESP;
              wr_ready_q <= 1'b1;
              resp_q     <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
              rd_ok_q <= addr_ok;
              if (READ_LATENCY == 1) begin
                state_q    <= READ_RESP;
                rd_ready_q <= 1'b1;
              end else begin
                cnt_q   <= LAT_M1;
                state_q <= READ_WAIT;
              end
            end
          end
        end
        READ_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= READ_RESP;
            rd_ready_q <= 1'b1;
          end
        end
        READ_RESP, WRITE_RESP: begin
          state_q <= IDLE;
          wait_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read_ready     = rd_ready_q;
  assign mem_write_ready    = wr_ready_q;
  assign mem_write_response = resp_q;
  assign error_count        = err_q;
  assign wait_request       = wait_q | stall;
  assign mem_read_data      = rd_ready_q ? (rd_ok_q ? arr_rdata : OOR_READ_VALUE) : hold_q;

endmodule

// File: tb/tb_dijkstra_mem_responder.sv
// Randomized self-checking bench for dijkstra_mem_responder against a shadow-array model.
module tb_dijkstra_mem_responder;
  localparam int          DEPTH = 1024;
  localparam int          RL    = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [15:0] OOR   = 16'hFFFF;

  logic        mem_clock, mem_reset;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_addr;
  logic [15:0] mem_write_data, mem_read_data, error_count;
  logic        mem_read_ready, mem_write_ready, wait_request;
  logic [1:0]  mem_write_response;

  dijkstra_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LATENCY(RL), .OOR_READ_VALUE(OOR)
  ) dut (
    .mem_clock(mem_clock), .mem_reset(mem_reset),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_read_ready(mem_read_ready),
    .mem_write_ready(mem_write_ready), .mem_write_response(mem_write_response),
    .wait_request(wait_request), .error_count(error_count)
  );

  initial mem_clock = 1'b0;
  always #5 mem_clock = ~mem_clock;

  logic [15:0] model [DEPTH];
  int exp_err;
  int n_checks, n_fail;

  function automatic bit addr_valid(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off % 2 == 0) && (off < 2 * DEPTH);
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 2);
  endfunction

  // Drives one request, holds it until accepted, then observes six cycles.
  task automatic bus_op(input logic re, input logic we, input logic [31:0] a,
                        input logic [15:0] d, output int rd_n, output int rd_k,
                        output logic [15:0] rdat, output int wr_n, output int wr_k,
                        output logic [1:0] resp, output logic [7:0] wbits);
    int guard;
    rd_n = 0; rd_k = 0; rdat = '0; wr_n = 0; wr_k = 0; resp = '0; wbits = '0; guard = 0;
    @(negedge mem_clock);
    mem_read_enable = re; mem_write_enable = we; mem_addr = a; mem_write_data = d;
    while (wait_request && guard < 200) begin
      @(negedge mem_clock);
      guard++;
    end
    if (wait_request) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: wait_request stuck at %b, required 0", wait_request);
      mem_read_enable = 1'b0; mem_write_enable = 1'b0;
      return;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge mem_clock);
      if (k == 1) begin mem_read_enable = 1'b0; mem_write_enable = 1'b0; end
      wbits[k] = wait_request;
      if (mem_read_ready)  begin rd_n++; rd_k = k; rdat = mem_read_data; end
      if (mem_write_ready) begin wr_n++; wr_k = k; resp = mem_write_response; end
    end
  endtask

  task automatic test_reset();
    mem_reset = 1'b0; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
    mem_addr = '0; mem_write_data = '0; exp_err = 0;
    repeat (3) @(negedge mem_clock);
    n_checks++;
    if ({mem_read_data, mem_read_ready, mem_write_ready, mem_write_response, wait_request, error_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%h rr=%b wr=%b resp=%b wait=%b err=%h, required all 0",
               mem_read_data, mem_read_ready, mem_write_ready, mem_write_response, wait_request, error_count);
    end
    mem_reset = 1'b1;
  endtask

  task automatic test_fill();
    int rn, rk, wn, wk; logic [15:0] rd, d; logic [1:0] rs; logic [7:0] wb;
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'($urandom);
      bus_op(1'b0, 1'b1, BASE + 32'(2 * i), d, rn, rk, rd, wn, wk, rs, wb);
      model[i] = d;
      n_checks++;
      if (wn !== 1 || rs !== 2'b00) begin
        n_fail++;
        $display("FAIL fill_write[%0d]: got pulses=%0d resp=%b, required 1 and 00", i, wn, rs);
      end
    end
  endtask

  task automatic test_write_read();
    int rn, rk, wn, wk; logic [15:0] rd; logic [1:0] rs; logic [7:0] wb;
    bus_op(1'b0, 1'b1, BASE + 32'd4, 16'h1234, rn, rk, rd, wn, wk, rs, wb);
    model[2] = 16'h1234;
    n_checks++;
    if (wn !== 1 || wk !== 1 || rs !== 2'b00 || rn !== 0) begin
      n_fail++;
      $display("FAIL write_timing: got wr_n=%0d wr_k=%0d resp=%b rd_n=%0d, required 1 1 00 0", wn, wk, rs, rn);
    end
    n_checks++;
    if (wb[1] !== 1'b1) begin
      n_fail++; $display("FAIL write_wait: got wait=%b in response cycle, required 1", wb[1]);
    end
    bus_op(1'b1, 1'b0, BASE + 32'd4, 16'h0, rn, rk, rd, wn, wk, rs, wb);
    n_checks++;
    if (rn !== 1 || rk !== RL || rd !== 16'h1234) begin
      n_fail++;
      $display("FAIL read_after_write: got n=%0d k=%0d data=%h, required 1 %0d 1234", rn, rk, rd, RL);
    end
    n_checks++;
    if (wb[RL:1] !== '1) begin
      n_fail++; $display("FAIL read_wait_high: got %b, required all 1", wb[RL:1]);
    end
`ifndef DIJKSTRA_MEM_RESPONDER_STALL_EN
    n_checks++;
    if (wb[RL+1] !== 1'b0) begin
      n_fail++; $display("FAIL read_wait_release: got %b, required 0", wb[RL+1]);
    end
`endif
  endtask

  task automatic test_oor_read();
    int rn, rk, wn, wk; logic [15:0] rd; logic [1:0] rs; logic [7:0] wb;
    bus_op(1'b1, 1'b0, BASE + 32'(2 * DEPTH), 16'h0, rn, rk, rd, wn, wk, rs, wb);
    n_checks++;
    if (rn !== 1 || rd !== OOR) begin
      n_fail++; $display("FAIL oor_read: got n=%0d data=%h, required 1 %h", rn, rd, OOR);
    end
    bus_op(1'b1, 1'b0, BASE + 32'd1, 16'h0, rn, rk, rd, wn, wk, rs, wb);
    n_checks++;
    if (rn !== 1 || rd !== OOR) begin
      n_fail++; $display("FAIL misaligned_read: got n=%0d data=%h, required 1 %h", rn, rd, OOR);
    end
    exp_err += 2;
    n_checks++;
    if (error_count !== 16'd2) begin
      n_fail++; $display("FAIL oor_err_count: got %0d, required 2", error_count);
    end
  endtask

  task automatic test_oor_write();
    int rn, rk, wn, wk, bad; logic [15:0] rd; logic [1:0] rs; logic [7:0] wb;
    bus_op(1'b0, 1'b1, BASE + 32'(2 * DEPTH), 16'hBEEF, rn, rk, rd, wn, wk, rs, wb);
    exp_err += 1;
    n_checks++;
    if (wn !== 1 || rs !== 2'b10) begin
      n_fail++; $display("FAIL oor_write_resp: got n=%0d resp=%b, required 1 10", wn, rs);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus_op(1'b1, 1'b0, BASE + 32'(2 * i), 16'h0, rn, rk, rd, wn, wk, rs, wb);
      n_checks++;
      if (rd !== model[i] || rn !== 1) begin
        n_fail++; bad++;
        if (bad < 8) $display("FAIL array_unchanged[%0d]: got %h, required %h", i, rd, model[i]);
      end
    end
    n_checks++;
    if (error_count !== 16'(exp_err)) begin
      n_fail++; $display("FAIL oor_write_err: got %0d, required %0d", error_count, exp_err);
    end
  endtask

  task automatic test_both_enables();
    int rn, rk, wn, wk; logic [15:0] rd; logic [1:0] rs; logic [7:0] wb;
    bus_op(1'b1, 1'b1, BASE, 16'h00AA, rn, rk, rd, wn, wk, rs, wb);
    model[0] = 16'h00AA;
    exp_err += 1;
    n_checks++;
    if (wn !== 1 || rs !== 2'b00 || rn !== 0) begin
      n_fail++; $display("FAIL both_enables: got wr_n=%0d resp=%b rd_n=%0d, required 1 00 0", wn, rs, rn);
    end
    n_checks++;
    if (error_count !== 16'(exp_err)) begin
      n_fail++; $display("FAIL both_err: got %0d, required %0d", error_count, exp_err);
    end
    bus_op(1'b1, 1'b0, BASE, 16'h0, rn, rk, rd, wn, wk, rs, wb);
    n_checks++;
    if (rd !== 16'h00AA) begin
      n_fail++; $display("FAIL both_readback: got %h, required 00aa", rd);
    end
  endtask

  task automatic test_mid_reset();
    int guard, pulses, rn, rk, wn, wk; logic [15:0] rd; logic [1:0] rs; logic [7:0] wb;
    guard = 0;
    @(negedge mem_clock);
    mem_read_enable = 1'b1; mem_addr = BASE + 32'd8;
    while (wait_request && guard < 200) begin @(negedge mem_clock); guard++; end
    @(negedge mem_clock);
    mem_read_enable = 1'b0;
    mem_reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_read_ready, mem_write_ready, mem_write_response, wait_request, error_count, mem_read_data} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rr=%b wait=%b err=%h data=%h, required all 0",
               mem_read_ready, wait_request, error_count, mem_read_data);
    end
    @(negedge mem_clock);
    mem_reset = 1'b1;
    exp_err = 0;
    #1;
    n_checks++;
    if (wait_request !== 1'b0) begin
      n_fail++; $display("FAIL midreset_wait: got %b, required 0", wait_request);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge mem_clock);
      if (mem_read_ready) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL midreset_no_pulse: got %0d pulses, required 0", pulses);
    end
    bus_op(1'b1, 1'b0, BASE + 32'd8, 16'h0, rn, rk, rd, wn, wk, rs, wb);
    n_checks++;
    if (rn !== 1 || rk !== RL || rd !== model[4]) begin
      n_fail++; $display("FAIL midreset_read: got n=%0d k=%0d data=%h, required 1 %0d %h", rn, rk, rd, RL, model[4]);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [31:0] addrs [N];
    logic [15:0] expq [$];
    int acc [N];
    int n, rx, c;
    bit adv;
    for (int i = 0; i < N; i++) begin
      addrs[i] = BASE + 32'(2 * $urandom_range(0, DEPTH - 1));
      expq.push_back(model[addr_idx(addrs[i])]);
    end
    n = 0; rx = 0; adv = 0; c = 0;
    @(negedge mem_clock);
    mem_read_enable = 1'b1; mem_addr = addrs[0];
    while ((n < N || rx < N) && c < 800) begin
      if (adv) begin
        adv = 0;
        if (n < N) mem_addr = addrs[n]; else mem_read_enable = 1'b0;
      end
      if (mem_read_ready) begin
        n_checks++;
        if (mem_read_data !== expq[0]) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h, required %h", rx, mem_read_data, expq[0]);
        end
        void'(expq.pop_front());
        rx++;
      end
      if (mem_read_enable && !wait_request) begin
        acc[n] = c; n++; adv = 1;
      end
      @(negedge mem_clock);
      c++;
    end
    mem_read_enable = 1'b0;
    n_checks++;
    if (rx != N) begin
      n_fail++; $display("FAIL b2b_count: got %0d reads, required %0d", rx, N);
    end
`ifndef DIJKSTRA_MEM_RESPONDER_STALL_EN
    for (int i = 1; i < N; i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != RL + 1) begin
        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d", i, acc[i] - acc[i-1], RL + 1);
      end
    end
`endif
  endtask

  task automatic test_random();
    int rn, rk, wn, wk, kind, ix; logic [15:0] rd, d; logic [1:0] rs; logic [7:0] wb;
    logic [31:0] a; logic re, we; bit v;
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      ix = $urandom_range(0, 31);
      d = 16'($urandom);
      a = BASE + 32'(2 * ix);
      re = (kind >= 4 && kind <= 7) || kind == 9 || (kind == 8 && $urandom_range(0, 1) == 1);
      we = kind <= 3 || kind == 9 || (kind == 8 && !re);
      if (kind == 8) begin
        case ($urandom_range(0, 2))
          0:       a = BASE + 32'(2 * DEPTH) + 32'(2 * ix);
          1:       a = BASE - 32'd2;
          default: a = a + 32'd1;
        endcase
      end
      v = addr_valid(a);
      bus_op(re, we, a, d, rn, rk, rd, wn, wk, rs, wb);
      if (we) begin
        n_checks++;
        if (wn !== 1 || wk !== 1 || rn !== 0 || rs !== (v ? 2'b00 : 2'b10)) begin
          n_fail++;
          $display("FAIL rand_write[%0d] a=%h: got wr_n=%0d wr_k=%0d rd_n=%0d resp=%b, required 1 1 0 %b",
                   t, a, wn, wk, rn, rs, v ? 2'b00 : 2'b10);
        end
        if (v) model[addr_idx(a)] = d;
        exp_err += (v ? 0 : 1) + (re ? 1 : 0);
      end else begin
        n_checks++;
        if (rn !== 1 || rk !== RL || rd !== (v ? model[addr_idx(a)] : OOR)) begin
          n_fail++;
          $display("FAIL rand_read[%0d] a=%h: got n=%0d k=%0d data=%h, required 1 %0d %h",
                   t, a, rn, rk, rd, RL, v ? model[addr_idx(a)] : OOR);
        end
        exp_err += v ? 0 : 1;
      end
      n_checks++;
      if (error_count !== 16'(exp_err)) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %0d, required %0d", t, error_count, exp_err);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    test_reset();
    test_fill();
    test_write_read();
    test_oor_read();
    test_oor_write();
    test_both_enables();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
